axi_slave_mem: RTL and testbench
================================

# axi_slave_mem

AXI slave endpoint with an internal byte-writable word memory. It sits directly downstream of the AXI master interface and consumes its five channels: write address, write data (with WID), write response, read address and read data. Write and read paths are independent, and each has one outstanding transaction. The block is the default target for master-side bring-up and for system simulation.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width; must be 32 or 64
- AXI_ID_WIDTH, 16, ID width
- MEM_DEPTH, 256, memory words; must be a power of two

Ports:
- axi_clk_in  in  1  clock; all logic on rising edge
- axi_rstn_in  in  1  reset, synchronous, active-low
- axi_awaddr_in, axi_awburst_in, axi_awlen_in, axi_awsize_in, axi_awid_in, axi_awvalid_in  in  ADDR/2/8/3/ID/1  write address
- axi_awready_out  out  1
- axi_wdata_in, axi_wstrb_in, axi_wid_in, axi_wlast_in, axi_wvalid_in  in  DATA/DATA/8/ID/1/1  write data
- axi_wready_out  out  1
- axi_bid_out, axi_bresp_out, axi_bvalid_out  out  ID/2/1  write response
- axi_bready_in  in  1
- axi_araddr_in, axi_arburst_in, axi_arlen_in, axi_arsize_in, axi_arid_in, axi_arvalid_in  in  ADDR/2/8/3/ID/1  read address
- axi_arready_out  out  1
- axi_rdata_out, axi_rid_out, axi_rresp_out, axi_rlast_out, axi_rvalid_out  out  DATA/ID/2/1/1  read data
- axi_rready_in  in  1

## Operation
- Memory is indexed by word: idx = addr >> log2(DATA/8). A beat is out of range when addr >= MEM_DEPTH*DATA/8. Memory contents are not reset.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch addr, len, size, burst and id, clear the beat counter, and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb, advances the address, and increments the beat counter.
  - The burst ends on wlast or when the counter reaches len, whichever comes first. The block then goes to W_RESP.
  - W_RESP: bvalid=1 and bid=latched id. On B handshake, return to W_IDLE.
- Burst response (bresp) priority:
  1. DECERR if any beat was out of range. Out-of-range beats are accepted and discarded.
  2. SLVERR if any of the following holds: (1<<size) > DATA/8, burst==3, WRAP with len not in {1,3,7,15}, wid≠latched id on any beat, wlast early, or wlast missing on the final beat.
  3. Otherwise OKAY.
  - An illegal size or burst suppresses all memory writes for the burst; the beats are still consumed.
  - A beat with mismatched wid is not written.
- Address advance (bytes = 1<<size):
  - FIXED: address unchanged.
  - INCR: addr + bytes, truncated to AXI_ADDR_WIDTH.
  - WRAP: wsz = bytes*(len+1); next = (addr & ~(wsz-1)) | ((addr+bytes) & (wsz-1)).
  - An unaligned start is used as given; the word index drops the low bits.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch the control fields and go to R_DATA.
  - R_DATA: present rdata, rid and rresp for the current beat; rlast is asserted when beat==len.
  - rresp is computed per beat, with the same rules as bresp minus the W-channel checks. An error beat returns rdata=0.
  - On the R handshake of the last beat, return to R_IDLE.
- Simultaneous write and read of the same word in one cycle: the read beat presented that cycle carries the old data. The new data is visible from the next presented beat.

## Timing
- Reset values: awready=1, arready=1; wready, bvalid, rvalid and rlast are 0; bid, bresp, rid, rresp and rdata are 0. Both FSMs are in their IDLE state.
- Reset asserted mid-burst abandons the transaction. No B or R beat is issued for it, and bytes already written remain.
- AW handshake at edge N: awready=0 and wready=1 from N+1. The first beat can be accepted at edge N+1.
- W beats are accepted one per cycle with no bubbles.
- Last W beat at edge M: wready=0 and bvalid=1 from M+1. bvalid, bid and bresp hold until bready.
- B handshake at edge K: awready=1 from K+1. A new AW is accepted no earlier than K+1.
- AR handshake at edge N: rvalid=1 with beat 0 from N+1.
- Beat i is accepted at edge E, and beat i+1 is presented from E+1. The R channel streams one beat per cycle.
- While rready=0, rvalid, rdata, rid, rresp and rlast hold stable.
- Last R beat accepted at edge E: rvalid=0 and arready=1 from E+1.
- The write and read paths never stall each other.

## Test plan
- Single write, then single read. AW addr=0x10, len=0, size=2, INCR; W data=0xDEADBEEF, strb=0xF, wlast=1. Expect bresp=OKAY and bid=awid. Then AR addr=0x10 returns rdata=0xDEADBEEF, rlast=1, rresp=OKAY.
- INCR len=3 write at 0x20 with data 1..4, then a read of the same burst with rready toggling every cycle. Expect data 1,2,3,4 in order, rlast only on beat 3, and outputs stable while stalled.
- WRAP len=3, size=2, start 0x38 with data A,B,C,D. Expect words written at 0x38, 0x3C, 0x30, 0x34. An INCR read of 0x30 len=3 returns C,D,A,B.
- Partial strobe: after writing 0xFFFFFFFF to 0x40, write 0x12345678 with strb=0x5. A read of 0x40 returns 0xFF34FF78.
- Error cases:
  - Write at MEM_DEPTH*4 → DECERR, no memory change.
  - wlast on beat 1 of len=3 → SLVERR after 2 beats.
  - Read with size=3 when DATA=32 → rresp=SLVERR and rdata=0 on every beat.
- Reset asserted in the middle of a len=7 write (after 3 beats). Expect outputs at their reset values and no bvalid. A following single write/read pair completes with OKAY.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI slave endpoint backed by a byte-writable word memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding transaction each.
module axi_slave_mem #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 16,
    parameter int MEM_DEPTH      = 256
) (
    input  logic                        axi_clk_in,
    input  logic                        axi_rstn_in,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr_in,
    input  logic [1:0]                  axi_awburst_in,
    input  logic [7:0]                  axi_awlen_in,
    input  logic [2:0]                  axi_awsize_in,
    input  logic [AXI_ID_WIDTH-1:0]     axi_awid_in,
    input  logic                        axi_awvalid_in,
    output logic                        axi_awready_out,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata_in,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb_in,
    input  logic [AXI_ID_WIDTH-1:0]     axi_wid_in,
    input  logic                        axi_wlast_in,
    input  logic                        axi_wvalid_in,
    output logic                        axi_wready_out,
    output logic [AXI_ID_WIDTH-1:0]     axi_bid_out,
    output logic [1:0]                  axi_bresp_out,
    output logic                        axi_bvalid_out,
    input  logic                        axi_bready_in,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr_in,
    input  logic [1:0]                  axi_arburst_in,
    input  logic [7:0]                  axi_arlen_in,
    input  logic [2:0]                  axi_arsize_in,
    input  logic [AXI_ID_WIDTH-1:0]     axi_arid_in,
    input  logic                        axi_arvalid_in,
    output logic                        axi_arready_out,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata_out,
    output logic [AXI_ID_WIDTH-1:0]     axi_rid_out,
    output logic [1:0]                  axi_rresp_out,
    output logic                        axi_rlast_out,
    output logic                        axi_rvalid_out,
    input  logic                        axi_rready_in
);

    localparam int unsigned NBYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(NBYTES);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LIMIT = AXI_ADDR_WIDTH'(MEM_DEPTH * NBYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] ONE       = AXI_ADDR_WIDTH'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [2:0]                size,
        input logic [7:0]                len,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_WIDTH-1:0] bytes;
        logic [AXI_ADDR_WIDTH-1:0] wsz;
        bytes = ONE << size;
        wsz   = bytes * (AXI_ADDR_WIDTH'(len) + ONE);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~(wsz - ONE)) | ((addr + bytes) & (wsz - ONE));
            default: next_addr = addr + bytes;
        endcase
    endfunction

    function automatic logic illegal_ctrl(
        input logic [2:0] size,
        input logic [7:0] len,
        input logic [1:0] burst
    );
        illegal_ctrl = (size > 3'(LSB)) || (burst == 2'b11) ||
                       ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                              (len == 8'd7) || (len == 8'd15)));
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_e                  w_state_q, w_state_d;
    logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]                awlen_q, awlen_d;
    logic [2:0]                awsize_q, awsize_d;
    logic [1:0]                awburst_q, awburst_d;
    logic [AXI_ID_WIDTH-1:0]   awid_q, awid_d;
    logic [7:0]                wbeat_q, wbeat_d;
    logic                      dec_q, dec_d;
    logic                      slv_q, slv_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      mem_we;
    logic                      w_ill, w_oor, w_id_ok, w_final, w_beat_slv;

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        awid_d    = awid_q;
        wbeat_d   = wbeat_q;
        dec_d     = dec_q;
        slv_d     = slv_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        w_ill      = illegal_ctrl(awsize_q, awlen_q, awburst_q);
        w_oor      = waddr_q >= MEM_LIMIT;
        w_id_ok    = axi_wid_in == awid_q;
        w_final    = wbeat_q == awlen_q;
        // wlast must coincide exactly with the final beat: early or missing are both errors
        w_beat_slv = !w_id_ok || (axi_wlast_in != w_final);
        case (w_state_q)
            W_IDLE: begin
                if (axi_awvalid_in) begin
                    waddr_d   = axi_awaddr_in;
                    awlen_d   = axi_awlen_in;
                    awsize_d  = axi_awsize_in;
                    awburst_d = axi_awburst_in;
                    awid_d    = axi_awid_in;
                    wbeat_d   = '0;
                    dec_d     = 1'b0;
                    slv_d     = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_wvalid_in) begin
                    mem_we  = axi_rstn_in && !w_ill && !w_oor && w_id_ok;
                    waddr_d = next_addr(waddr_q, awsize_q, awlen_q, awburst_q);
                    wbeat_d = wbeat_q + 8'd1;
                    dec_d   = dec_q | w_oor;
                    slv_d   = slv_q | w_ill | w_beat_slv;
                    if (axi_wlast_in || w_final) begin
                        w_state_d = W_RESP;
                        bresp_d   = dec_d ? RESP_DECERR : (slv_d ? RESP_SLVERR : RESP_OKAY);
                    end
                end
            end
            W_RESP: begin
                if (axi_bready_in) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk_in) begin
        if (!axi_rstn_in) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            awid_q    <= '0;
            wbeat_q   <= '0;
            dec_q     <= 1'b0;
            slv_q     <= 1'b0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            awid_q    <= awid_d;
            wbeat_q   <= wbeat_d;
            dec_q     <= dec_d;
            slv_q     <= slv_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge axi_clk_in) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (axi_wstrb_in[b]) mem[waddr_q[LSB +: IDX_W]][b*8 +: 8] <= axi_wdata_in[b*8 +: 8];
            end
        end
    end

    assign axi_awready_out = (w_state_q == W_IDLE);
    assign axi_wready_out  = (w_state_q == W_DATA);
    assign axi_bvalid_out  = (w_state_q == W_RESP);
    assign axi_bid_out     = awid_q;
    assign axi_bresp_out   = bresp_q;

    r_state_e                  r_state_q, r_state_d;
    logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]                arlen_q, arlen_d;
    logic [2:0]                arsize_q, arsize_d;
    logic [1:0]                arburst_q, arburst_d;
    logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [7:0]                rbeat_q, rbeat_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      rlast_q, rlast_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]                rd_resp;
    logic [AXI_DATA_WIDTH-1:0] rd_data;

    // Beat data is registered when the beat is first presented, so a write landing on
    // the same edge is only seen by the following beat and stalled beats stay stable.
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rid_d     = rid_q;
        rbeat_d   = rbeat_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        if (r_state_q == R_IDLE) begin
            rd_addr = axi_araddr_in;
            rd_resp = (rd_addr >= MEM_LIMIT) ? RESP_DECERR :
                      (illegal_ctrl(axi_arsize_in, axi_arlen_in, axi_arburst_in) ? RESP_SLVERR : RESP_OKAY);
        end else begin
            rd_addr = next_addr(raddr_q, arsize_q, arlen_q, arburst_q);
            rd_resp = (rd_addr >= MEM_LIMIT) ? RESP_DECERR :
                      (illegal_ctrl(arsize_q, arlen_q, arburst_q) ? RESP_SLVERR : RESP_OKAY);
        end
        rd_data = (rd_resp == RESP_OKAY) ? mem[rd_addr[LSB +: IDX_W]] : '0;
        case (r_state_q)
            R_IDLE: begin
                if (axi_arvalid_in) begin
                    r_state_d = R_DATA;
                    raddr_d   = axi_araddr_in;
                    arlen_d   = axi_arlen_in;
                    arsize_d  = axi_arsize_in;
                    arburst_d = axi_arburst_in;
                    rid_d     = axi_arid_in;
                    rbeat_d   = '0;
                    rlast_d   = (axi_arlen_in == 8'd0);
                    rdata_d   = rd_data;
                    rresp_d   = rd_resp;
                end
            end
            R_DATA: begin
                if (axi_rready_in) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        raddr_d = rd_addr;
                        rbeat_d = rbeat_q + 8'd1;
                        rlast_d = ((rbeat_q + 8'd1) == arlen_q);
                        rdata_d = rd_data;
                        rresp_d = rd_resp;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk_in) begin
        if (!axi_rstn_in) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rid_q     <= '0;
            rbeat_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rid_q     <= rid_d;
            rbeat_q   <= rbeat_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign axi_arready_out = (r_state_q == R_IDLE);
    assign axi_rvalid_out  = (r_state_q == R_DATA);
    assign axi_rdata_out   = rdata_q;
    assign axi_rid_out     = rid_q;
    assign axi_rresp_out   = rresp_q;
    assign axi_rlast_out   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized self-checking bench for axi_slave_mem against a byte-array reference memory.
module tb_axi_slave_mem;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int DEPTH = 256;
    localparam int NB = DW / 8;
    localparam int MEM_BYTES = DEPTH * NB;

    logic          clk;
    logic          rstn;
    logic [AW-1:0] awaddr, araddr;
    logic [1:0]    awburst, arburst;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [IW-1:0] awid, arid, wid, bid, rid;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [NB-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    axi_slave_mem #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .axi_clk_in(clk), .axi_rstn_in(rstn),
        .axi_awaddr_in(awaddr), .axi_awburst_in(awburst), .axi_awlen_in(awlen), .axi_awsize_in(awsize),
        .axi_awid_in(awid), .axi_awvalid_in(awvalid), .axi_awready_out(awready),
        .axi_wdata_in(wdata), .axi_wstrb_in(wstrb), .axi_wid_in(wid), .axi_wlast_in(wlast),
        .axi_wvalid_in(wvalid), .axi_wready_out(wready),
        .axi_bid_out(bid), .axi_bresp_out(bresp), .axi_bvalid_out(bvalid), .axi_bready_in(bready),
        .axi_araddr_in(araddr), .axi_arburst_in(arburst), .axi_arlen_in(arlen), .axi_arsize_in(arsize),
        .axi_arid_in(arid), .axi_arvalid_in(arvalid), .axi_arready_out(arready),
        .axi_rdata_out(rdata), .axi_rid_out(rid), .axi_rresp_out(rresp), .axi_rlast_out(rlast),
        .axi_rvalid_out(rvalid), .axi_rready_in(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0]    ref_mem [MEM_BYTES];
    logic [DW-1:0] wd [256];
    logic [NB-1:0] ws [256];

    function automatic logic [31:0] mdl_next(input logic [31:0] a, input int size, input int len, input int burst);
        longint unsigned bytes, wsz, base;
        bytes = longint'(1) << size;
        if (burst == 0) return a;
        if (burst == 2) begin
            wsz  = bytes * longint'(len + 1);
            base = longint'(a) - (longint'(a) % wsz);
            return 32'(base + ((longint'(a) + bytes) % wsz));
        end
        return 32'(longint'(a) + bytes);
    endfunction

    function automatic bit mdl_illegal(input int size, input int len, input int burst);
        return ((1 << size) > NB) || (burst == 3) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic logic [DW-1:0] mdl_word(input logic [31:0] a);
        logic [DW-1:0] w;
        int base;
        base = int'(a / NB) * NB;
        for (int b = 0; b < NB; b++) w[b*8 +: 8] = ref_mem[base + b];
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, awready, 1);
        check({tag, "_arready"}, arready, 1);
        check({tag, "_wready"}, wready, 0);
        check({tag, "_bvalid"}, bvalid, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_rlast"}, rlast, 0);
        check({tag, "_bid"}, bid, 0);
        check({tag, "_bresp"}, bresp, 0);
        check({tag, "_rid"}, rid, 0);
        check({tag, "_rresp"}, rresp, 0);
        check({tag, "_rdata"}, rdata, 0);
    endtask

    task automatic send_aw(input logic [31:0] addr, input int len, input int size, input int burst,
                           input logic [IW-1:0] id);
        int n;
        @(negedge clk);
        awaddr = addr; awlen = len[7:0]; awsize = size[2:0]; awburst = burst[1:0]; awid = id;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check("aw_ready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        check("wready_after_aw", wready, 1);
        check("awready_busy", awready, 0);
    endtask

    // Drives one W beat and updates the reference memory; returns the beat's error contributions.
    task automatic send_w(input logic [31:0] a, input int i, input bit lst, input logic [IW-1:0] bw,
                          input logic [IW-1:0] id, input bit ill, output bit oor);
        oor = a >= MEM_BYTES;
        if (!oor && !ill && bw == id)
            for (int b = 0; b < NB; b++)
                if (ws[i][b]) ref_mem[int'(a / NB) * NB + b] = wd[i][b*8 +: 8];
        wdata = wd[i]; wstrb = ws[i]; wid = bw; wlast = lst; wvalid = 1'b1;
        check("wready_beat", wready, 1);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int size, input int burst,
                            input logic [IW-1:0] id, input int early_last, input bit drop_last,
                            input int bad_wid);
        bit ill, dec, slv, lst, oor;
        logic [31:0] a;
        logic [IW-1:0] bw;
        logic [1:0] exp;
        int k;
        send_aw(addr, len, size, burst, id);
        ill = mdl_illegal(size, len, burst);
        a = addr; dec = 0; slv = ill;
        for (int i = 0; i < 256; i++) begin
            lst = (i == early_last) || (i == len && !drop_last);
            bw  = (i == bad_wid) ? ~id : id;
            if (bw != id) slv = 1;
            if (lst != (i == len)) slv = 1;
            send_w(a, i, lst, bw, id, ill, oor);
            dec |= oor;
            a = mdl_next(a, size, len, burst);
            if (lst || i == len) break;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("wready_done", wready, 0);
        check("bvalid_set", bvalid, 1);
        exp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        k = $urandom % 3;
        repeat (k) begin
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp);
            check("awready_in_resp", awready, 0);
            @(negedge clk);
        end
        bready = 1'b1;
        check("bresp", bresp, exp);
        check("bid", bid, id);
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clr", bvalid, 0);
        check("awready_back", awready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input int size, input int burst,
                           input logic [IW-1:0] id, input bit toggle);
        bit ill, rr, tg;
        logic [31:0] a;
        logic [1:0] er;
        logic [DW-1:0] ed;
        int n;
        @(negedge clk);
        araddr = addr; arlen = len[7:0]; arsize = size[2:0]; arburst = burst[1:0]; arid = id;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_ready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_after_ar", rvalid, 1);
        check("arready_busy", arready, 0);
        ill = mdl_illegal(size, len, burst);
        a = addr; tg = 0;
        for (int i = 0; i <= len; i++) begin
            er = (a >= MEM_BYTES) ? 2'b11 : (ill ? 2'b10 : 2'b00);
            ed = (er == 2'b00) ? mdl_word(a) : '0;
            n = 0;
            forever begin
                check("rvalid", rvalid, 1);
                check("rdata", rdata, ed);
                check("rresp", rresp, er);
                check("rlast", rlast, (i == len));
                check("rid", rid, id);
                rr = toggle ? tg : 1'($urandom % 2);
                tg = ~tg;
                if (n >= 20) rr = 1;
                rready = rr;
                @(negedge clk);
                n++;
                if (rr) break;
            end
            a = mdl_next(a, size, len, burst);
        end
        rready = 1'b0;
        check("rvalid_clr", rvalid, 0);
        check("arready_back", arready, 1);
    endtask

    task automatic fill_beats(input int n);
        for (int i = 0; i < n; i++) begin wd[i] = $urandom; ws[i] = NB'($urandom); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wl [4];
        int size, burst, len, bad;
        logic [31:0] addr;
        bit oor;
        wl = '{1, 3, 7, 15};
        rstn = 0; awaddr = 0; awburst = 0; awlen = 0; awsize = 0; awid = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wid = 0; wlast = 0; wvalid = 0; bready = 0;
        araddr = 0; arburst = 0; arlen = 0; arsize = 0; arid = 0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1;

        // Full-memory INCR burst so every byte of the reference is known.
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = '1; end
        do_write(32'h0, 255, 2, 1, 16'h0101, -1, 0, -1);

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h10, 0, 2, 1, 16'h1234, -1, 0, -1);
        do_read(32'h10, 0, 2, 1, 16'h55AA, 0);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h20, 3, 2, 1, 16'h0002, -1, 0, -1);
        do_read(32'h20, 3, 2, 1, 16'h0003, 1);

        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(32'h38, 3, 2, 2, 16'h0004, -1, 0, -1);
        do_read(32'h30, 3, 2, 1, 16'h0005, 0);
        do_read(32'h34, 3, 2, 2, 16'h0006, 1);

        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(32'h40, 0, 2, 1, 16'h0007, -1, 0, -1);
        wd[0] = 32'h12345678; ws[0] = 4'h5;
        do_write(32'h40, 0, 2, 1, 16'h0008, -1, 0, -1);
        do_read(32'h40, 0, 2, 1, 16'h0009, 0);

        fill_beats(4);
        do_write(MEM_BYTES, 0, 2, 1, 16'h000A, -1, 0, -1);
        do_read(MEM_BYTES, 0, 2, 1, 16'h000B, 0);
        do_read(32'h0, 0, 2, 1, 16'h000C, 0);
        do_write(MEM_BYTES - 8, 3, 2, 1, 16'h000D, -1, 0, -1);
        do_read(MEM_BYTES - 8, 3, 2, 1, 16'h000E, 0);

        fill_beats(4);
        do_write(32'h60, 3, 2, 1, 16'h0010, 1, 0, -1);
        fill_beats(4);
        do_write(32'h70, 1, 2, 1, 16'h0011, -1, 1, -1);
        fill_beats(4);
        do_write(32'h80, 3, 2, 1, 16'h0012, -1, 0, 2);
        do_read(32'h60, 11, 2, 1, 16'h0013, 0);

        do_read(32'h40, 1, 3, 1, 16'h0014, 0);
        fill_beats(4);
        do_write(32'h90, 1, 3, 1, 16'h0015, -1, 0, -1);
        fill_beats(4);
        do_write(32'h98, 1, 2, 3, 16'h0016, -1, 0, -1);
        do_read(32'h90, 3, 2, 1, 16'h0017, 0);

        fill_beats(4);
        do_write(32'hA0, 3, 2, 0, 16'h0018, -1, 0, -1);
        do_read(32'hA0, 2, 2, 0, 16'h0019, 0);
        fill_beats(6);
        do_write(32'hB1, 5, 0, 1, 16'h001A, -1, 0, -1);
        do_read(32'hB0, 2, 1, 1, 16'h001B, 0);

        // Reset in the middle of a len=7 write, after three accepted beats.
        fill_beats(8);
        send_aw(32'hC0, 7, 2, 1, 16'h0020);
        addr = 32'hC0;
        for (int i = 0; i < 3; i++) begin
            send_w(addr, i, 1'b0, 16'h0020, 16'h0020, 1'b0, oor);
            addr = mdl_next(addr, 2, 7, 1);
        end
        wvalid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rstn = 1'b1;
        fill_beats(1);
        do_write(32'hE0, 0, 2, 1, 16'h0021, -1, 0, -1);
        do_read(32'hE0, 0, 2, 1, 16'h0022, 0);
        do_read(32'hC0, 7, 2, 1, 16'h0023, 0);

        for (int it = 0; it < 40; it++) begin
            size  = $urandom % 3;
            burst = $urandom % 3;
            len   = (burst == 2) ? wl[$urandom % 4] : int'($urandom % 8);
            addr  = $urandom % (MEM_BYTES + 64);
            if ($urandom % 2) begin
                fill_beats(len + 1);
                bad = ($urandom % 8 == 0) ? int'($urandom % (len + 1)) : -1;
                do_write(addr, len, size, burst, IW'($urandom), -1, 0, bad);
            end else begin
                do_read(addr, len, size, burst, IW'($urandom), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
